// File: rtl/keypad_pkg.sv
// Shared key codes, debounce state encoding and key-class helper for the
// keypad entry path.
package keypad_pkg;

  localparam logic [5:0] KEY_NONE      = 6'd41;
  localparam logic [5:0] KEY_STAR      = 6'd10;
  localparam logic [5:0] KEY_HASH      = 6'd11;
  localparam logic [5:0] KEY_MAX_VALID = 6'd11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } deb_state_t;

  // Anything outside 0..11 (including KEY_NONE) is treated as "no key".
  function automatic logic is_key(input logic [5:0] code);
    return code <= KEY_MAX_VALID;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Registers the decoder key code, debounces press and release, and emits a
// single accepted-key strobe per physical press.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int RELEASE_CYC  = 20
) (
  input  logic       clk1k,
  input  logic       rst,
  input  logic [5:0] i_num,
  output logic       o_key_pulse,
  output logic [3:0] o_key_code,
  output logic       o_accept,
  output logic [3:0] o_accept_code
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(RELEASE_CYC + 1);

  logic [5:0]  r_num_q;
  deb_state_t  r_state, w_state_next;
  logic [3:0]  r_cand, w_cand_next;
  logic [DW-1:0] r_cnt, w_cnt_next;
  logic [RW-1:0] r_rcnt, w_rcnt_next;
  logic        r_key_pulse;
  logic [3:0]  r_key_code;
  logic        w_valid, w_match, w_accept;

  assign w_valid = is_key(r_num_q);
  assign w_match = w_valid && (r_num_q[3:0] == r_cand);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk1k or posedge rst) begin
    if (rst) begin
      r_num_q     <= KEY_NONE;
      r_state     <= IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_rcnt      <= '0;
      r_key_pulse <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_num_q     <= i_num;
      r_state     <= w_state_next;
      r_cand      <= w_cand_next;
      r_cnt       <= w_cnt_next;
      r_rcnt      <= w_rcnt_next;
      r_key_pulse <= w_accept;
      if (w_accept) r_key_code <= r_cand;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_rcnt_next  = r_rcnt;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_cand_next  = r_num_q[3:0];
          w_cnt_next   = DW'(1);
          w_state_next = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!w_valid) begin
          w_state_next = IDLE;
        end else if (!w_match) begin
          w_cand_next = r_num_q[3:0];
          w_cnt_next  = DW'(1);
        end else begin
          w_cnt_next = r_cnt + DW'(1);
          if (w_accept) w_state_next = PRESSED;
        end
      end
      PRESSED: begin
        if (!w_valid) begin
          w_rcnt_next  = RW'(1);
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (w_valid) begin
          w_state_next = PRESSED;
        end else begin
          w_rcnt_next = r_rcnt + RW'(1);
          if (r_rcnt >= RW'(RELEASE_CYC - 1)) w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Accept fires on the edge where the stable-sample count reaches DEBOUNCE_CYC.
  always_comb begin
    w_accept = (r_state == DEBOUNCE) && w_match && (r_cnt >= DW'(DEBOUNCE_CYC - 1));
  end

  assign o_key_pulse   = r_key_pulse;
  assign o_key_code    = r_key_code;
  assign o_accept      = w_accept;
  assign o_accept_code = r_cand;

endmodule

// File: rtl/keypad_entry_buffer.sv
// Keypad digit entry: accumulates up to MAX_DIGITS decimal digits and commits
// a range-checked seconds setpoint on '#', '*' clears the entry.
module keypad_entry_buffer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 20,
  parameter int RELEASE_CYC  = 20,
  parameter int MAX_DIGITS   = 3,
  parameter int MAX_VALUE    = 300,
  parameter int VALUE_W      = 10
) (
  input  logic                               clk1k,
  input  logic                               rst,
  input  logic [5:0]                         num,
  output logic                               key_pulse,
  output logic [3:0]                         key_code,
  output logic [4*MAX_DIGITS-1:0]            digits,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic [VALUE_W-1:0]                 value,
  output logic                               value_valid,
  output logic                               entry_error
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  logic                    w_accept;
  logic [3:0]              w_code;
  logic [4*MAX_DIGITS-1:0] r_digits;
  logic [CW-1:0]           r_count;
  logic [VALUE_W-1:0]      r_acc, r_value;
  logic                    r_value_valid, r_entry_error;
  logic [VALUE_W-1:0]      w_acc_next;
  logic                    w_full, w_out_of_range;

  key_debouncer #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .RELEASE_CYC  (RELEASE_CYC)
  ) u_deb (
    .clk1k         (clk1k),
    .rst           (rst),
    .i_num         (num),
    .o_key_pulse   (key_pulse),
    .o_key_code    (key_code),
    .o_accept      (w_accept),
    .o_accept_code (w_code)
  );

  // acc*10 as shift-add; VALUE_W is sized so a full buffer never overflows.
  assign w_acc_next     = (r_acc << 3) + (r_acc << 1) + VALUE_W'(w_code);
  assign w_full         = (r_count >= CW'(MAX_DIGITS));
  assign w_out_of_range = (r_acc == '0) || (r_acc > VALUE_W'(MAX_VALUE));

  always_ff @(posedge clk1k or posedge rst) begin
    if (rst) begin
      r_digits      <= '0;
      r_count       <= '0;
      r_acc         <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      r_entry_error <= 1'b0;
    end else begin
      r_value_valid <= 1'b0;
      r_entry_error <= 1'b0;
      if (w_accept) begin
        if (w_code <= 4'd9) begin
          if (w_full) begin
            r_entry_error <= 1'b1;
          end else begin
            r_digits <= {r_digits[4*MAX_DIGITS-5:0], w_code};
            r_acc    <= w_acc_next;
            r_count  <= r_count + CW'(1);
          end
        end else if (w_code == KEY_STAR[3:0]) begin
          r_digits <= '0;
          r_acc    <= '0;
          r_count  <= '0;
        end else if (r_count == '0) begin
          r_entry_error <= 1'b1;
        end else begin
          // Any '#' with digits present ends the entry, accepted or not.
          r_digits <= '0;
          r_acc    <= '0;
          r_count  <= '0;
          if (w_out_of_range) begin
            r_entry_error <= 1'b1;
          end else begin
            r_value       <= r_acc;
            r_value_valid <= 1'b1;
          end
        end
      end
    end
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign value       = r_value;
  assign value_valid = r_value_valid;
  assign entry_error = r_entry_error;

endmodule

// File: tb/tb_keypad_entry_buffer.sv
// Directed bench for keypad_entry_buffer: debounce timing, bounce rejection,
// digit entry, commit range checks and reset mid-press.
`timescale 1ns/1ps
module tb_keypad_entry_buffer;
  import keypad_pkg::*;

  logic        clk1k = 1'b0;
  logic        rst;
  logic [5:0]  num;
  logic        key_pulse;
  logic [3:0]  key_code;
  logic [11:0] digits;
  logic [1:0]  digit_count;
  logic [9:0]  value;
  logic        value_valid;
  logic        entry_error;

  int n_vec  = 0;
  int n_miss = 0;
  int step_i = 0;
  int n_pulse, n_vv, n_err, n_bad, pulse_at;

  keypad_entry_buffer dut (
    .clk1k       (clk1k),
    .rst         (rst),
    .num         (num),
    .key_pulse   (key_pulse),
    .key_code    (key_code),
    .digits      (digits),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .entry_error (entry_error)
  );

  always #5 clk1k = ~clk1k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clear_mon();
    n_pulse = 0; n_vv = 0; n_err = 0; n_bad = 0; pulse_at = -1; step_i = 0;
  endtask

  // One clock, sampled 1 ns after the rising edge; tallies the strobes.
  task automatic step();
    @(posedge clk1k);
    #1;
    step_i++;
    if (key_pulse) begin n_pulse++; pulse_at = step_i; end
    if (value_valid) n_vv++;
    if (entry_error) n_err++;
    if ((value_valid || entry_error) && !key_pulse) n_bad++;
    if (value_valid && entry_error) n_bad++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic press(input logic [5:0] k);
    num = k;
    run(30);
    num = KEY_NONE;
    run(25);
  endtask

  initial begin
    rst = 1'b1;
    num = KEY_NONE;
    clear_mon();
    repeat (3) @(posedge clk1k);
    #1 rst = 1'b0;

    // 1: reset state and idle with no key
    check("rst_digits", digits, 0);
    check("rst_count", digit_count, 0);
    check("rst_value", value, 0);
    check("rst_code", key_code, 0);
    run(100);
    check("idle_pulses", n_pulse, 0);
    check("idle_strobes", n_vv + n_err, 0);

    // 2: clean press of 7, pulse 21 edges after the change
    clear_mon();
    num = 6'd7;
    run(50);
    num = KEY_NONE;
    run(30);
    check("p7_pulses", n_pulse, 1);
    check("p7_latency", pulse_at, 21);
    check("p7_code", key_code, 7);
    check("p7_digits", digits, 12'h007);
    check("p7_count", digit_count, 1);

    // 3: bouncy press of 3 with a glitch during release
    clear_mon();
    num = 6'd3;     run(5);
    num = KEY_NONE; run(2);
    num = 6'd3;     run(25);
    num = KEY_NONE; run(5);
    num = 6'd3;     run(1);
    num = KEY_NONE; run(30);
    check("b3_pulses", n_pulse, 1);
    check("b3_code", key_code, 3);
    check("b3_digits", digits, 12'h073);

    // '*' clears the pending entry
    clear_mon();
    press(KEY_STAR);
    check("star_digits", digits, 0);
    check("star_count", digit_count, 0);
    check("star_strobes", n_vv + n_err, 0);
    check("star_code", key_code, 10);

    // 4: 1,2,0,# commits 120
    clear_mon();
    press(6'd1); press(6'd2); press(6'd0);
    check("e120_digits", digits, 12'h120);
    check("e120_count", digit_count, 3);
    check("e120_pulses", n_pulse, 3);
    clear_mon();
    press(KEY_HASH);
    check("c120_value", value, 120);
    check("c120_vv", n_vv, 1);
    check("c120_err", n_err, 0);
    check("c120_digits", digits, 0);
    check("c120_count", digit_count, 0);

    // 5: 999 out of range, then overflow on the 4th digit
    clear_mon();
    press(6'd9); press(6'd9); press(6'd9); press(KEY_HASH);
    check("c999_err", n_err, 1);
    check("c999_vv", n_vv, 0);
    check("c999_value", value, 120);
    check("c999_digits", digits, 0);
    clear_mon();
    press(6'd1); press(6'd2); press(6'd3);
    check("e123_err", n_err, 0);
    press(6'd4);
    check("e1234_err", n_err, 1);
    check("e1234_digits", digits, 12'h123);
    check("e1234_count", digit_count, 3);

    // Boundaries: 300 accepted, 301 and 0 rejected
    clear_mon();
    press(KEY_STAR);
    press(6'd3); press(6'd0); press(6'd0); press(KEY_HASH);
    check("c300_value", value, 300);
    check("c300_vv", n_vv, 1);
    clear_mon();
    press(6'd3); press(6'd0); press(6'd1); press(KEY_HASH);
    check("c301_err", n_err, 1);
    check("c301_value", value, 300);
    clear_mon();
    press(6'd0); press(KEY_HASH);
    check("c0_err", n_err, 1);
    check("c0_value", value, 300);

    // 6: 5, '*', '#' on empty buffer
    clear_mon();
    press(6'd5);
    check("e5_digits", digits, 12'h005);
    press(KEY_STAR);
    check("e5_star_digits", digits, 0);
    check("e5_star_err", n_err, 0);
    press(KEY_HASH);
    check("empty_hash_err", n_err, 1);
    check("empty_hash_vv", n_vv, 0);
    check("strobe_alignment", n_bad, 0);

    // Reset asserted while key 8 is still debouncing
    clear_mon();
    num = 6'd8;
    run(10);
    check("k8_state_deb", dut.u_deb.r_state, DEBOUNCE);
    rst = 1'b1;
    num = KEY_NONE;
    run(2);
    rst = 1'b0;
    run(40);
    check("k8_pulses", n_pulse, 0);
    check("k8_state", dut.u_deb.r_state, IDLE);
    check("k8_value", value, 0);
    check("k8_code", key_code, 0);
    check("k8_count", digit_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
